// File: rtl/sr_drv_pkg.sv
// Shared types and default constants for the SR latch driver.
// Optional pulse stretching is enabled with SR_DRV_PULSE_STRETCH_EN (see sr_latch_driver).
package sr_drv_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        SET_P = 3'd2,
        RST_P = 3'd3,
        GUARD = 3'd4
    } sr_drv_state_e;

    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_GUARD_CYC    = 2;
    localparam int DEF_STRETCH_CYC  = 4;

endpackage

// File: rtl/sr_latch_debounce.sv
// One button channel: 2-flop synchronizer, counter-based debounce and a
// single-cycle rise strobe on each accepted low-to-high transition.
module sr_debounce
    import sr_drv_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             stable_d;
    logic             stable_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle where the synchronized level agrees with the stable level
    // restarts the count, so a short glitch can never be accepted.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
            stable_d = sync_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q        <= 1'b0;
            sync_q        <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            meta_q        <= btn_i;
            sync_q        <= meta_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    assign rise_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Drives a NOR SR latch from two bouncy buttons: debounced, mutually exclusive
// S/R pulses with guard gaps. Define SR_DRV_PULSE_STRETCH_EN for STRETCH_CYC-long pulses.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int GUARD_CYC      = DEF_GUARD_CYC,
    parameter int RESET_PRIORITY = 1
`ifdef SR_DRV_PULSE_STRETCH_EN
    ,
    parameter int STRETCH_CYC    = DEF_STRETCH_CYC
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_btn,
    input  logic          rst_btn,
    output logic          s_out,
    output logic          r_out,
    output logic          busy,
    output sr_drv_state_e dbg_state_o
);

    localparam int GCW = $clog2(GUARD_CYC + 1) + 1;

    logic           rise_s;
    logic           rise_r;
    logic           want_s;
    logic           want_r;
    logic           r_first;
    logic           issue_ok;
    logic           pulse_done;
    sr_drv_state_e  state_q;
    logic           s_q;
    logic           r_q;
    logic           busy_q;
    logic           pend_s_q;
    logic           pend_r_q;
    logic [GCW-1:0] gcnt_q;

    sr_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_deb_set (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .btn_i  (set_btn),
        .rise_o (rise_s)
    );

    sr_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_deb_rst (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .btn_i  (rst_btn),
        .rise_o (rise_r)
    );

    assign want_s   = pend_s_q | rise_s;
    assign want_r   = pend_r_q | rise_r;
    assign r_first  = want_r & (~want_s | (RESET_PRIORITY != 0));
    assign issue_ok = (state_q == IDLE) | ((state_q == GUARD) & (gcnt_q == '0));

`ifdef SR_DRV_PULSE_STRETCH_EN
    localparam int SCW = $clog2(STRETCH_CYC) + 1;
    logic [SCW-1:0] scnt_q;

    // Loaded as a pulse is issued; the pulse ends on the cycle it reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q <= '0;
        end else if ((state_q != INIT) && issue_ok && (want_s || want_r)) begin
            scnt_q <= SCW'(STRETCH_CYC - 1);
        end else if (scnt_q != '0) begin
            scnt_q <= scnt_q - SCW'(1);
        end
    end

    assign pulse_done = (scnt_q == '0);
`else
    assign pulse_done = 1'b1;
`endif

    // The INIT pulse lands while the state already reads GUARD, so its guard
    // count is one longer to give GUARD_CYC idle cycles after the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            busy_q   <= 1'b0;
            pend_s_q <= 1'b0;
            pend_r_q <= 1'b0;
            gcnt_q   <= '0;
        end else if (state_q == INIT) begin
            state_q  <= GUARD;
            s_q      <= 1'b0;
            r_q      <= 1'b1;
            busy_q   <= 1'b1;
            gcnt_q   <= GCW'(GUARD_CYC);
            pend_s_q <= want_s;
            pend_r_q <= want_r;
        end else if (issue_ok) begin
            if (r_first) begin
                state_q  <= RST_P;
                s_q      <= 1'b0;
                r_q      <= 1'b1;
                busy_q   <= 1'b1;
                pend_r_q <= 1'b0;
                pend_s_q <= want_s;
            end else if (want_s) begin
                state_q  <= SET_P;
                s_q      <= 1'b1;
                r_q      <= 1'b0;
                busy_q   <= 1'b1;
                pend_s_q <= 1'b0;
                pend_r_q <= want_r;
            end else begin
                state_q  <= IDLE;
                s_q      <= 1'b0;
                r_q      <= 1'b0;
                busy_q   <= 1'b0;
            end
        end else begin
            pend_s_q <= want_s;
            pend_r_q <= want_r;
            case (state_q)
                SET_P, RST_P: begin
                    if (pulse_done) begin
                        state_q <= GUARD;
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        gcnt_q  <= GCW'(GUARD_CYC - 1);
                    end
                end
                GUARD: begin
                    s_q    <= 1'b0;
                    r_q    <= 1'b0;
                    gcnt_q <= gcnt_q - GCW'(1);
                end
                default: begin
                    state_q <= IDLE;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_out       = s_q;
    assign r_out       = r_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Upstream driver stage for the cross-coupled NOR SR latch.
- Takes two raw, bouncy, asynchronous push-button inputs (set and reset).
- Synchronizes and debounces them, then emits clean, registered, mutually exclusive S/R pulses separated by guard gaps.
- Issues a power-up reset pulse so the latch leaves its undefined initial state with Q=0.

Parameters:
- DEBOUNCE_CYC, 4: cycles a synchronized input must differ from its debounced state before the change is accepted; legal range >=2.
- CNT_W, 8: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYC.
- GUARD_CYC, 2: idle cycles with s_out=r_out=0 after every pulse; legal range >=1.
- RESET_PRIORITY, 1: on simultaneous set/reset requests, 1 = reset first, 0 = set first.

Ports:
- clk, input, 1: single clock; all state is on the rising edge.
- rst_n, input, 1: asynchronous assert, active-low reset.
- set_btn, input, 1: raw asynchronous set button, active-high.
- rst_btn, input, 1: raw asynchronous reset button, active-high.
- s_out, output, 1: registered set pulse to the latch S input.
- r_out, output, 1: registered reset pulse to the latch R input.
- busy, output, 1: high whenever the FSM is not in IDLE.

Interface rule (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values: all state clears while rst_n=0. This covers sync flops, counters, debounced levels, pending flags and guard counter. Outputs read s_out=0, r_out=0, busy=0, FSM=INIT.
- Synchronizer: 2-flop synchronizer per button.
- Debounce, per channel:
  - stable level register plus counter cnt.
  - If sync==stable: cnt<=0.
  - Else if cnt==DEBOUNCE_CYC-1: stable<=sync, cnt<=0.
  - Else: cnt<=cnt+1.
  - A single-cycle glitch resets cnt; it never changes stable.
- Request: rise = stable & ~stable_d. Only rising edges generate requests; falling edges are ignored.
- Latency: for a clean input first sampled high at edge 1, s_out (or r_out) goes high after edge DEBOUNCE_CYC+3 (edge 7 for the default) and stays high for exactly 1 cycle.
- FSM states: INIT, IDLE, SET_P, RST_P, GUARD.
  - INIT: entered on reset release. Drives r_out=1 for 1 cycle, then GUARD.
  - IDLE: with a set request only, go to SET_P. With a reset request only, go to RST_P. With both in the same cycle, the RESET_PRIORITY winner goes first and the other is stored in its pending flag.
  - SET_P: s_out=1, r_out=0, for 1 cycle; then GUARD.
  - RST_P: r_out=1, s_out=0, for 1 cycle; then GUARD.
  - GUARD: both outputs 0 for GUARD_CYC cycles. Then serve a pending flag if any; if both are pending, RESET_PRIORITY decides. Otherwise return to IDLE.
- Pending flags: a request arriving in any state other than IDLE sets its pending flag. The flag is 1 deep; repeated requests of the same type while pending collapse into one. The flag clears when its pulse is issued.
- Invariant: s_out & r_out is never 1 in any cycle, including reset and INIT.
- Reset mid-pulse: outputs drop to 0 asynchronously and pending flags are discarded. After release, INIT runs again.
- Buttons held high produce no further pulses until released and re-pressed (each release must pass debounce).

Optional Feature:
- Macro: SR_DRV_PULSE_STRETCH_EN.
- Defined: adds parameter STRETCH_CYC (default 4, >=1). SET_P and RST_P hold their output for STRETCH_CYC cycles using a shared stretch counter. Requests arriving during the stretch become pending. Latency to the first asserted cycle is unchanged.
- Undefined: pulses are exactly 1 cycle and no stretch counter exists.

Decomposition:
- Package sr_drv_pkg:
  - enum sr_drv_state_e {INIT, IDLE, SET_P, RST_P, GUARD}.
  - Default constants DEF_DEBOUNCE_CYC, DEF_GUARD_CYC, DEF_STRETCH_CYC.
- Sub-module sr_debounce: one channel covering the 2-flop synchronizer, counter, stable register and rise output. Instantiated twice, once for set_btn and once for rst_btn.
- Top level holds the FSM, pending flags and guard counter.

Test Plan:
- Power-up: assert rst_n=0 for 3 cycles, then release -> r_out=1 for exactly 1 cycle on the first edge after release; busy=1 for 1+GUARD_CYC cycles; then IDLE with s_out=r_out=0.
- Clean set (defaults): set_btn high from edge 1 -> s_out=1 only after edge 7, r_out=0 throughout, then busy=1 through a 2-cycle guard.
- Bounce: set_btn toggles 1,0,1,0 cycle by cycle, then holds high -> no pulse during toggling; exactly one s_out pulse DEBOUNCE_CYC+3 edges after the final rise.
- Simultaneous press: both buttons rise on the same edge with RESET_PRIORITY=1 -> r_out pulse, 2 idle cycles, then s_out pulse; never both high. Repeat with RESET_PRIORITY=0 -> order swaps.
- Reset mid-operation: rst_n=0 while s_out=1 and a reset request is pending -> s_out drops immediately, no r_out from the pending flag; after release, only the INIT r_out pulse appears.
- Stretch (SR_DRV_PULSE_STRETCH_EN, STRETCH_CYC=4): clean reset press -> r_out high for exactly 4 consecutive cycles starting at edge 7, followed by GUARD_CYC zero cycles.
